// File: rtl/vend_controller.sv
// Vending sequencer: collects coin credit, requests one dispense, then pays change
// unit by unit. A dispenser that never acknowledges latches fault and refunds.
//
//   state    | meaning
//   IDLE     | no credit held, waiting for coins
//   CREDIT   | partial credit held, below price
//   DISPENSE | disp_req raised, waiting for disp_ack or timeout
//   CHANGE   | paying out remaining credit through chg_req/chg_ack
module vend_controller #(
  parameter int CREDIT_W   = 4,
  parameter int PRICE      = 6,
  parameter int VAL_A      = 2,
  parameter int VAL_B      = 1,
  parameter int MAX_CREDIT = 9,
  parameter int TIMEOUT    = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_a,
  input  logic                coin_b,
  input  logic                cancel,
  input  logic                disp_ack,
  input  logic                chg_ack,
  output logic                disp_req,
  output logic                chg_req,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                fault,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CREDIT   = 3'd1,
    S_DISPENSE = 3'd2,
    S_CHANGE   = 3'd3
  } state_t;

  localparam logic [CREDIT_W:0]   VAL_A_W    = (CREDIT_W+1)'(VAL_A);
  localparam logic [CREDIT_W:0]   VAL_B_W    = (CREDIT_W+1)'(VAL_B);
  localparam logic [CREDIT_W:0]   MAX_W      = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] ONE_C      = CREDIT_W'(1);
  localparam logic [3:0]          TIMER_LOAD = 4'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [3:0]            timer_q, timer_d;
  logic                  fault_q, fault_d;
  logic                  reject_d;
  logic [CREDIT_W:0]     coin_val;
  logic [CREDIT_W:0]     credit_sum;
  logic                  coin_any;

  // Extra bit on the sum so an over-credit coin is seen instead of wrapping.
  always_comb begin
    coin_val   = (coin_a ? VAL_A_W : '0) + (coin_b ? VAL_B_W : '0);
    credit_sum = {1'b0, credit_q} + coin_val;
    coin_any   = (coin_val != '0);
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    timer_d  = timer_q;
    fault_d  = fault_q;
    reject_d = 1'b0;
    case (state_q)
      S_IDLE, S_CREDIT: begin
        if ((state_q == S_CREDIT) && cancel) begin
          reject_d = coin_any;
          state_d  = S_CHANGE;
        end else begin
          if (coin_any) begin
            if (fault_q || (credit_sum > MAX_W))
              reject_d = 1'b1;
            else
              credit_d = credit_sum[CREDIT_W-1:0];
          end
          if (credit_d >= PRICE_C) begin
            state_d = S_DISPENSE;
            timer_d = TIMER_LOAD;
          end else if (credit_d != '0) begin
            state_d = S_CREDIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DISPENSE: begin
        reject_d = coin_any;
        if (disp_ack) begin
          credit_d = credit_q - PRICE_C;
          state_d  = (credit_q == PRICE_C) ? S_IDLE : S_CHANGE;
        end else if (timer_q == '0) begin
          fault_d = 1'b1;
          state_d = S_CHANGE;
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      S_CHANGE: begin
        reject_d = coin_any;
        if (chg_ack && (credit_q != '0)) begin
          credit_d = credit_q - ONE_C;
          if (credit_q == ONE_C)
            state_d = S_IDLE;
        end
      end
      default: begin
        reject_d = coin_any;
        state_d  = S_IDLE;
        credit_d = '0;
        timer_d  = '0;
      end
    endcase
  end

  // Request/busy flops decode the next state so they track the state register exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      credit_q    <= '0;
      timer_q     <= '0;
      fault_q     <= 1'b0;
      coin_reject <= 1'b0;
      disp_req    <= 1'b0;
      chg_req     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      timer_q     <= timer_d;
      fault_q     <= fault_d;
      coin_reject <= reject_d;
      disp_req    <= (state_d == S_DISPENSE);
      chg_req     <= (state_d == S_CHANGE);
      busy        <= (state_d == S_DISPENSE) || (state_d == S_CHANGE);
    end
  end

  assign credit = credit_q;
  assign fault  = fault_q;
  assign state  = state_q;

endmodule

// File: tb/tb_vend_controller.sv
// Randomized bench: two controllers (default pricing, and price 9 so the
// over-credit limit is reachable) checked cycle by cycle against a credit-ledger model.
module tb_vend_controller;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] cr;
    logic       dr;
    logic       cq;
    logic       rj;
    logic       bz;
    logic       ft;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coin_a, coin_b, cancel, disp_ack, chg_ack;
  logic [1:0] disp_req, chg_req, coin_reject, busy, fault;
  logic [3:0] credit [2];
  logic [2:0] state  [2];

  always #5 clk = ~clk;

  vend_controller dut0 (
    .clk(clk), .rst(rst), .coin_a(coin_a[0]), .coin_b(coin_b[0]), .cancel(cancel[0]),
    .disp_ack(disp_ack[0]), .chg_ack(chg_ack[0]), .disp_req(disp_req[0]),
    .chg_req(chg_req[0]), .coin_reject(coin_reject[0]), .credit(credit[0]),
    .busy(busy[0]), .fault(fault[0]), .state(state[0])
  );

  vend_controller #(.PRICE(9), .TIMEOUT(5)) dut1 (
    .clk(clk), .rst(rst), .coin_a(coin_a[1]), .coin_b(coin_b[1]), .cancel(cancel[1]),
    .disp_ack(disp_ack[1]), .chg_ack(chg_ack[1]), .disp_req(disp_req[1]),
    .chg_req(chg_req[1]), .coin_reject(coin_reject[1]), .credit(credit[1]),
    .busy(busy[1]), .fault(fault[1]), .state(state[1])
  );

  int   price_m [2] = '{6, 9};
  int   max_m   [2] = '{9, 9};
  int   tmo_m   [2] = '{15, 5};

  // Ledger: money held, whether a drink is owed, whether change is owed.
  int   m_credit [2];
  bit   m_disp   [2];
  bit   m_pay    [2];
  bit   m_fault  [2];
  int   m_wait   [2];

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic model_step(input int i, input bit r, input bit a, input bit b,
                            input bit c, input bit da, input bit ca);
    exp_t e;
    int   v;
    bit   rej;
    v   = 2 * int'(a) + int'(b);
    rej = 1'b0;
    if (!r) begin
      m_credit[i] = 0; m_disp[i] = 0; m_pay[i] = 0; m_fault[i] = 0; m_wait[i] = 0;
    end else if (m_disp[i]) begin
      rej = (v > 0);
      if (da) begin
        m_credit[i] -= price_m[i];
        m_disp[i] = 0;
        m_pay[i]  = (m_credit[i] > 0);
      end else begin
        m_wait[i]++;
        if (m_wait[i] >= tmo_m[i]) begin
          m_fault[i] = 1; m_disp[i] = 0; m_pay[i] = 1;
        end
      end
    end else if (m_pay[i]) begin
      rej = (v > 0);
      if (ca && m_credit[i] > 0) begin
        m_credit[i]--;
        if (m_credit[i] == 0) m_pay[i] = 0;
      end
    end else begin
      if (c && m_credit[i] > 0) begin
        rej = (v > 0);
        m_pay[i] = 1;
      end else begin
        if (v > 0) begin
          if (m_fault[i] || (m_credit[i] + v > max_m[i])) rej = 1'b1;
          else m_credit[i] += v;
        end
        if (m_credit[i] >= price_m[i]) begin
          m_disp[i] = 1; m_wait[i] = 0;
        end
      end
    end
    e.st = m_pay[i] ? 3'd3 : m_disp[i] ? 3'd2 : (m_credit[i] > 0) ? 3'd1 : 3'd0;
    e.cr = 4'(m_credit[i]);
    e.dr = m_disp[i];
    e.cq = m_pay[i];
    e.rj = rej;
    e.bz = m_disp[i] | m_pay[i];
    e.ft = m_fault[i];
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Monitor: the controller presents its full output set every cycle.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if ((i == 0) ? (q0.size() > 0) : (q1.size() > 0)) begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          a = {state[i], credit[i], disp_req[i], chg_req[i], coin_reject[i], busy[i], fault[i]};
          n_cmp++;
          if (a !== e) begin
            n_bad++;
            $display("FAIL dut%0d outputs @%0t: got st=%0d cr=%0d dr=%b cq=%b rj=%b bz=%b ft=%b, expected st=%0d cr=%0d dr=%b cq=%b rj=%b bz=%b ft=%b",
                     i, $time, a.st, a.cr, a.dr, a.cq, a.rj, a.bz, a.ft,
                     e.st, e.cr, e.dr, e.cq, e.rj, e.bz, e.ft);
          end
        end
      end
    end
  end

  initial begin
    int ack_pct [2];
    rst = 1'b0;
    coin_a = '0; coin_b = '0; cancel = '0; disp_ack = '0; chg_ack = '0;
    for (int ep = 0; ep < 12; ep++) begin
      for (int i = 0; i < 2; i++) begin
        case ($urandom_range(0, 2))
          0:       ack_pct[i] = 0;
          1:       ack_pct[i] = 12;
          default: ack_pct[i] = 50;
        endcase
      end
      for (int cyc = 0; cyc < 250; cyc++) begin
        @(negedge clk);
        #1;
        rst = !((cyc < 2) || ($urandom_range(0, 399) == 0));
        for (int i = 0; i < 2; i++) begin
          coin_a[i]   = ($urandom_range(0, 99) < 25);
          coin_b[i]   = ($urandom_range(0, 99) < 25);
          cancel[i]   = ($urandom_range(0, 99) < 5);
          disp_ack[i] = ($urandom_range(0, 99) < ack_pct[i]);
          chg_ack[i]  = ($urandom_range(0, 99) < 50);
          model_step(i, rst, coin_a[i], coin_b[i], cancel[i], disp_ack[i], chg_ack[i]);
        end
      end
    end
    @(negedge clk);
    #1;
    coin_a = '0; coin_b = '0; cancel = '0; disp_ack = '0; chg_ack = '0;
    repeat (3) @(negedge clk);
    #1;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: pending expectations dut0=%0d dut1=%0d, expected 0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
